zap_wb_ram_slave: RTL

Wishbone B3 registered-feedback responder (slave) backed by a synchronous word RAM. It is the target end of the ZAP external Wishbone bus and supports classic cycles and linear incrementing bursts (CTI 010/111), as issued by the ZAP cache line fills and writebacks. It serves as the on-chip memory model for the ZAP testbench and SoC, and makes burst cache traffic single-cycle per beat.

---
 rtl/zap_wb_ram_slave.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/zap_wb_ram_slave.sv
// zap_wb_ram_slave: Wishbone B3 registered-feedback slave backed by a
// synchronous word RAM. Handles classic cycles and linear incrementing
// bursts (CTI 010 / 111) with optional wait states before the first ack.
//
// state | meaning
// IDLE  | no transfer; waiting for cyc & stb
// WAIT  | counting down wait states before the first ack
// ACK   | first beat acked this cycle
// BURST | burst beat acked this cycle, one beat per clock
module zap_wb_ram_slave #(
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_wb_cyc,
  input  logic        i_wb_stb,
  input  logic        i_wb_we,
  input  logic [31:0] i_wb_adr,
  input  logic [31:0] i_wb_dat,
  input  logic [3:0]  i_wb_sel,
  input  logic [2:0]  i_wb_cti,
  output logic        o_wb_ack,
  output logic [31:0] o_wb_dat
);

  localparam int         AW = $clog2(DEPTH);
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  typedef enum logic [1:0] {IDLE, WAIT, ACK, BURST} state_t;

  logic [31:0]   mem [DEPTH];
  state_t        state;
  logic [3:0]    wait_cnt;
  logic [AW-1:0] burst_idx;
  logic [AW-1:0] adr_idx;
  logic [AW-1:0] next_idx;
  logic [AW-1:0] rd_idx;
  logic          req;
  logic          cti_inc;
  logic          cti_end;
  logic          mem_we;

  // Address bits outside the word index are ignored, so the RAM aliases.
  logic unused_adr;
  assign unused_adr = ^{i_wb_adr[31:AW+2], i_wb_adr[1:0]};

  assign adr_idx  = i_wb_adr[AW+1:2];
  assign next_idx = burst_idx + AW'(1);
  assign req      = i_wb_cyc & i_wb_stb;
  assign cti_inc  = (i_wb_cti == 3'b010);
  assign cti_end  = (i_wb_cti == 3'b111);

  // Writes commit only on the edge that ends an acked beat; an aborted
  // burst beat (cyc low) or a reset leaves the RAM untouched.
  assign mem_we = ((state == ACK) || (state == BURST)) & req & i_wb_we;

  // Single read address: request index for zero-wait first beats, the
  // latched index after wait states, and the predicted next index in bursts.
  always_comb begin
    rd_idx = adr_idx;
    case (state)
      WAIT:       rd_idx = burst_idx;
      ACK, BURST: rd_idx = next_idx;
      default:    rd_idx = adr_idx;
    endcase
  end

  // Byte-masked RAM write port.
  always_ff @(posedge i_clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (i_wb_sel[b]) mem[adr_idx][8*b +: 8] <= i_wb_dat[8*b +: 8];
      end
    end
  end

  // Transfer FSM with registered ack and read data.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state     <= IDLE;
      o_wb_ack  <= 1'b0;
      o_wb_dat  <= 32'h0;
      wait_cnt  <= 4'd0;
      burst_idx <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            burst_idx <= adr_idx;
            wait_cnt  <= WS;
            if (WAIT_STATES == 0) begin
              o_wb_ack <= 1'b1;
              if (!i_wb_we) o_wb_dat <= mem[rd_idx];
              state <= ACK;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          wait_cnt <= wait_cnt - 4'd1;
          if (!i_wb_cyc) begin
            state <= IDLE;
          end else if (wait_cnt == 4'd1) begin
            // stb must still be high when the count expires to get an ack.
            if (i_wb_stb) begin
              o_wb_ack <= 1'b1;
              if (!i_wb_we) o_wb_dat <= mem[rd_idx];
              state <= ACK;
            end else begin
              state <= IDLE;
            end
          end
        end
        ACK: begin
          if (i_wb_cyc && cti_inc) begin
            burst_idx <= next_idx;
            if (!i_wb_we) o_wb_dat <= mem[rd_idx];
            state <= BURST;
          end else begin
            // Dropping to IDLE forces a one-cycle gap between classic cycles.
            o_wb_ack <= 1'b0;
            state    <= IDLE;
          end
        end
        BURST: begin
          if (!i_wb_cyc || cti_end) begin
            o_wb_ack <= 1'b0;
            state    <= IDLE;
          end else begin
            burst_idx <= next_idx;
            if (!i_wb_we) o_wb_dat <= mem[rd_idx];
          end
        end
        default: begin
          o_wb_ack <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule
